// File: rtl/dbg_bus_pkg.sv
// Shared definitions for the debug-bus mailbox target.
// Holds the host command codes, the address field widths, the status-word
// layout, and a helper that assembles the status word from its fields.
package dbg_bus_pkg;

    localparam int ADDR_ID_W  = 4;
    localparam int ADDR_CMD_W = 4;

    typedef enum logic [ADDR_CMD_W-1:0] {
        DBG_CMD_PUSH = 4'h0,
        DBG_CMD_POP  = 4'h1,
        DBG_CMD_STAT = 4'h2,
        DBG_CMD_CLR  = 4'h3
    } dbg_cmd_e;

    localparam logic [7:0] STAT_MAGIC   = 8'hB1;
    localparam int         STAT_OVF_BIT = 16;
    localparam int         STAT_UNF_BIT = 17;
    localparam int         STAT_COL_BIT = 18;

    // Status word: magic in [63:56], sticky flags in [18:16],
    // OUT count in [15:8], IN count in [7:0]; every other bit is zero.
    function automatic logic [63:0] build_status(
        input logic       ovf,
        input logic       unf,
        input logic       col,
        input logic [7:0] out_cnt,
        input logic [7:0] in_cnt
    );
        logic [63:0] s;
        s                = '0;
        s[63:56]         = STAT_MAGIC;
        s[STAT_COL_BIT]  = col;
        s[STAT_UNF_BIT]  = unf;
        s[STAT_OVF_BIT]  = ovf;
        s[15:8]          = out_cnt;
        s[7:0]           = in_cnt;
        return s;
    endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Synchronous single-clock FIFO used for both mailbox directions.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        synchronous flush (same effect as reset on the pointers)
//   push/wdata write request; accepted only when not full at the start of the cycle
//   pop/rdata  read request; rdata is the current head (show-ahead)
//   full/empty/count  occupancy; count is 0..DEPTH
module dbg_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Full is judged before any same-cycle pop: a push into a full FIFO is
    // dropped even if a pop frees a slot in that cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbg_mailbox.sv
// Debug-bus mailbox target: a 64-bit host->core FIFO (IN) and core->host
// FIFO (OUT), with sticky error flags and a pollable status word.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   debug_bus_addr        [7:4] target id, [3:0] command
//   debug_bus_start       one-cycle command strobe
//   debug_bus_data        inout: PUSH data in; response data out while pending
//   debug_bus_available   inout: driven 1 while a response is pending, else 'z
//   debug_bus_accepted    host has consumed the pending response
//   core_rx_*             IN FIFO head towards core logic
//   core_tx_*             core logic words into the OUT FIFO
// Core handshakes: a word moves exactly in a cycle where valid and ready are
// both high at the clock edge; valid never depends on ready. In a CLR cycle
// core_rx_valid and core_tx_ready are forced low so no word is half-moved.
module dbg_mailbox
    import dbg_bus_pkg::*;
#(
    parameter logic [ADDR_ID_W-1:0] TARGET_ID = 4'h3,
    parameter int                   DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  debug_bus_addr,
    input  logic        debug_bus_start,
    inout  wire  [63:0] debug_bus_data,
    inout  wire         debug_bus_available,
    input  logic        debug_bus_accepted,
    output logic [63:0] core_rx_data,
    output logic        core_rx_valid,
    input  logic        core_rx_ready,
    input  logic [63:0] core_tx_data,
    input  logic        core_tx_valid,
    output logic        core_tx_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  resp_pending;
    logic [63:0]           resp_data;
    logic                  flag_ovf;
    logic                  flag_unf;
    logic                  flag_col;

    logic [ADDR_CMD_W-1:0] cmd;
    logic                  id_match;
    logic                  hit;
    logic                  collide;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_stat;
    logic                  do_clr;

    logic                  in_full;
    logic                  in_empty;
    logic [CW-1:0]         in_count;
    logic                  in_pop;
    logic [63:0]           out_head;
    logic                  out_full;
    logic                  out_empty;
    logic [CW-1:0]         out_count;
    logic                  out_push;
    logic [63:0]           status_word;

    assign cmd      = debug_bus_addr[ADDR_CMD_W-1:0];
    assign id_match = (debug_bus_addr[7:4] == TARGET_ID);
    assign hit      = debug_bus_start & id_match & ~resp_pending;
    // A start for us while a response is still outstanding is dropped and
    // recorded, so the host can tell it issued commands too fast.
    assign collide  = debug_bus_start & id_match & resp_pending;

    assign do_push  = hit & (cmd == DBG_CMD_PUSH);
    assign do_pop   = hit & (cmd == DBG_CMD_POP);
    assign do_stat  = hit & (cmd == DBG_CMD_STAT);
    assign do_clr   = hit & (cmd == DBG_CMD_CLR);

    assign core_rx_valid = ~in_empty & ~do_clr;
    assign core_tx_ready = ~out_full & ~do_clr;
    assign in_pop        = core_rx_valid & core_rx_ready;
    assign out_push      = core_tx_valid & core_tx_ready;

    assign status_word = build_status(flag_ovf, flag_unf, flag_col,
                                      8'(out_count), 8'(in_count));

    dbg_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (do_clr),
        .push  (do_push),
        .wdata (debug_bus_data),
        .pop   (in_pop),
        .rdata (core_rx_data),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    dbg_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (do_clr),
        .push  (out_push),
        .wdata (core_tx_data),
        .pop   (do_pop),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always_ff @(posedge clk) begin
        if (rst || do_clr) begin
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_col <= 1'b0;
        end else begin
            if (do_push && in_full) begin
                flag_ovf <= 1'b1;
            end
            if (do_pop && out_empty) begin
                flag_unf <= 1'b1;
            end
            if (collide) begin
                flag_col <= 1'b1;
            end
        end
    end

    // Response register: captured in the hit cycle, held until the host
    // accepts, then released so the bus floats from the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_pending <= 1'b0;
            resp_data    <= '0;
        end else if (do_pop) begin
            resp_pending <= 1'b1;
            resp_data    <= out_empty ? 64'h0 : out_head;
        end else if (do_stat) begin
            resp_pending <= 1'b1;
            resp_data    <= status_word;
        end else if (resp_pending && debug_bus_accepted) begin
            resp_pending <= 1'b0;
        end
    end

    assign debug_bus_data      = resp_pending ? resp_data : 64'bz;
    assign debug_bus_available = resp_pending ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_dbg_mailbox.sv
module tb_dbg_mailbox;
    import dbg_bus_pkg::*;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  debug_bus_addr;
    logic        debug_bus_start;
    wire  [63:0] debug_bus_data;
    wire         debug_bus_available;
    logic        debug_bus_accepted;
    logic [63:0] core_rx_data;
    logic        core_rx_valid;
    logic        core_rx_ready;
    logic [63:0] core_tx_data;
    logic        core_tx_valid;
    logic        core_tx_ready;

    logic        tb_drv;
    logic [63:0] tb_data;

    assign debug_bus_data = tb_drv ? tb_data : 64'bz;

    dbg_mailbox #(.TARGET_ID(4'h3), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .debug_bus_addr      (debug_bus_addr),
        .debug_bus_start     (debug_bus_start),
        .debug_bus_data      (debug_bus_data),
        .debug_bus_available (debug_bus_available),
        .debug_bus_accepted  (debug_bus_accepted),
        .core_rx_data        (core_rx_data),
        .core_rx_valid       (core_rx_valid),
        .core_rx_ready       (core_rx_ready),
        .core_tx_data        (core_tx_data),
        .core_tx_valid       (core_tx_valid),
        .core_tx_ready       (core_tx_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard / model ----------------
    logic [63:0] exp_q[$];   // expected host responses, in order
    logic [63:0] rx_q[$];    // model of IN FIFO contents
    logic [63:0] out_q[$];   // model of OUT FIFO contents
    logic        m_ovf, m_unf, m_col;

    function automatic logic [63:0] model_status();
        logic [7:0] oc, ic;
        oc = 8'(out_q.size());
        ic = 8'(rx_q.size());
        return {8'hB1, 37'b0, m_col, m_unf, m_ovf, oc, ic};
    endfunction

    task automatic model_clear();
        rx_q.delete();
        out_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_col = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic host_cmd(input logic [3:0] id, input logic [3:0] cmd, input logic [63:0] d);
        debug_bus_addr  = {id, cmd};
        debug_bus_start = 1'b1;
        tb_drv          = (cmd == DBG_CMD_PUSH);
        tb_data         = d;
        cyc();
        debug_bus_start = 1'b0;
        tb_drv          = 1'b0;
    endtask

    task automatic get_resp(input string name);
        int          waited;
        logic [63:0] exp;
        waited = 0;
        while (debug_bus_available !== 1'b1 && waited < 10) begin
            cyc();
            waited++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
        checks++;
        if (debug_bus_available !== 1'b1) begin
            errors++;
            $display("FAIL %s_avail: got %b want 1 (timeout)", name, debug_bus_available);
            return;
        end
        checks++;
        if (debug_bus_data !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h want %h", name, debug_bus_data, exp);
        end
        cyc();
        checks++;
        if (debug_bus_available !== 1'b1 || debug_bus_data !== exp) begin
            errors++;
            $display("FAIL %s_hold: got avail=%b data=%h want 1 %h", name, debug_bus_available, debug_bus_data, exp);
        end
        debug_bus_accepted = 1'b1;
        cyc();
        debug_bus_accepted = 1'b0;
        checks++;
        if (debug_bus_available === 1'b1) begin
            errors++;
            $display("FAIL %s_release: got avail=%b want z", name, debug_bus_available);
        end
    endtask

    task automatic host_push(input logic [63:0] d);
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else m_ovf = 1'b1;
        host_cmd(4'h3, DBG_CMD_PUSH, d);
    endtask

    task automatic host_pop(input string name);
        if (out_q.size() > 0) exp_q.push_back(out_q.pop_front());
        else begin
            exp_q.push_back(64'h0);
            m_unf = 1'b1;
        end
        host_cmd(4'h3, DBG_CMD_POP, 64'h0);
        get_resp(name);
    endtask

    task automatic host_stat(input string name);
        exp_q.push_back(model_status());
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp(name);
    endtask

    task automatic host_clr();
        model_clear();
        host_cmd(4'h3, DBG_CMD_CLR, 64'h0);
    endtask

    task automatic core_push(input logic [63:0] d);
        checks++;
        if (core_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL core_tx_ready: got %b want 1", core_tx_ready);
        end
        core_tx_valid = 1'b1;
        core_tx_data  = d;
        out_q.push_back(d);
        cyc();
        core_tx_valid = 1'b0;
    endtask

    // Drain IN until the model is empty (bounded), comparing every word.
    task automatic core_drain(input string name);
        int budget;
        budget = 0;
        core_rx_ready = 1'b1;
        while (rx_q.size() > 0 && budget < 3 * DEPTH) begin
            if (core_rx_valid === 1'b1) begin
                checks++;
                if (core_rx_data !== rx_q[0]) begin
                    errors++;
                    $display("FAIL %s_word: got %h want %h", name, core_rx_data, rx_q[0]);
                end
                void'(rx_q.pop_front());
            end
            cyc();
            budget++;
        end
        core_rx_ready = 1'b0;
        checks++;
        if (rx_q.size() != 0 || core_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: got valid=%b left=%0d want 0 0", name, core_rx_valid, rx_q.size());
            rx_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_clear();
        checks++;
        if (core_rx_valid !== 1'b0 || core_tx_ready !== 1'b1 || debug_bus_available === 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got rx_valid=%b tx_ready=%b avail=%b want 0 1 z",
                     core_rx_valid, core_tx_ready, debug_bus_available);
        end
        exp_q.push_back(64'hB100_0000_0000_0000);
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp("reset_stat");
    endtask

    task automatic test_push_rx();
        host_push(64'h1122);
        checks++;
        if (core_rx_valid !== 1'b1 || core_rx_data !== 64'h1122) begin
            errors++;
            $display("FAIL push_rx: got valid=%b data=%h want 1 1122", core_rx_valid, core_rx_data);
        end
        core_drain("push_rx");
    endtask

    task automatic test_tx_pop();
        core_push(64'hAAAA_0000_0000_000A);
        core_push(64'hBBBB_0000_0000_000B);
        host_pop("pop_a");
        host_pop("pop_b");
        exp_q.push_back(64'hB100_0000_0000_0000);
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp("pop_stat");
    endtask

    task automatic test_underflow_clr();
        host_pop("unf_pop");
        exp_q.push_back(64'hB100_0000_0002_0000);
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp("unf_stat");
        host_clr();
        host_stat("clr_stat");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) begin
            host_push({$urandom(), $urandom()});
        end
        exp_q.push_back(64'hB100_0000_0001_0010);
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp("ovf_stat");
        core_drain("ovf_drain");
        host_clr();
    endtask

    task automatic test_collision();
        exp_q.push_back(model_status());
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        m_col = 1'b1;
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp("col_first");
        checks++;
        if (model_status() !== 64'hB100_0000_0004_0000) begin
            errors++;
            $display("FAIL col_model: got %h want B100000000040000", model_status());
        end
        host_stat("col_stat");
        host_clr();
    endtask

    task automatic test_back_to_back();
        logic [63:0] x, y;
        x = {$urandom(), $urandom()};
        y = {$urandom(), $urandom()};
        host_push(x);
        // core pops X in the same cycle the host pushes Y
        core_rx_ready = 1'b1;
        checks++;
        if (core_rx_valid !== 1'b1 || core_rx_data !== x) begin
            errors++;
            $display("FAIL b2b_head: got valid=%b data=%h want 1 %h", core_rx_valid, core_rx_data, x);
        end
        void'(rx_q.pop_front());
        host_push(y);
        core_rx_ready = 1'b0;
        host_stat("b2b_stat");
        // random OUT traffic
        for (int i = 0; i < 4; i++) core_push({$urandom(), $urandom_range(0, 1000)});
        for (int i = 0; i < 4; i++) host_pop("b2b_pop");
        core_drain("b2b_drain");
    endtask

    task automatic test_reset_mid();
        host_push(64'h5555);
        core_push(64'h6666);
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        checks++;
        if (debug_bus_available !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending: got %b want 1", debug_bus_available);
        end
        rst = 1'b1;
        debug_bus_addr  = {4'h5, DBG_CMD_STAT};
        debug_bus_start = 1'b1;
        cyc();
        rst = 1'b0;
        debug_bus_start = 1'b0;
        model_clear();
        checks++;
        if (debug_bus_available === 1'b1 || core_rx_valid !== 1'b0 || core_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs: got avail=%b rx_valid=%b tx_ready=%b want z 0 1",
                     debug_bus_available, core_rx_valid, core_tx_ready);
        end
        host_cmd(4'h5, DBG_CMD_POP, 64'h0);
        host_cmd(4'h5, DBG_CMD_STAT, 64'h0);
        checks++;
        if (debug_bus_available === 1'b1) begin
            errors++;
            $display("FAIL rstmid_id5: got avail=%b want z", debug_bus_available);
        end
        exp_q.push_back(64'hB100_0000_0000_0000);
        host_cmd(4'h3, DBG_CMD_STAT, 64'h0);
        get_resp("rstmid_stat");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst                = 1'b1;
        debug_bus_addr     = '0;
        debug_bus_start    = 1'b0;
        debug_bus_accepted = 1'b0;
        core_rx_ready      = 1'b0;
        core_tx_data       = '0;
        core_tx_valid      = 1'b0;
        tb_drv             = 1'b0;
        tb_data            = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_col = 1'b0;

        test_reset();
        test_push_rx();
        test_tx_pop();
        test_underflow_clr();
        test_overflow();
        test_collision();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
